// File: rtl/mtm_alu_deserializer.sv
// Serial packet receiver for the ALU input: 11-bit frames (start, type, payload[7:0], stop),
// 8 DATA frames + 1 CTL frame per packet, presented as A/B/op/crc with one-cycle status pulses.
module mtm_alu_deserializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic [3:0]  crc,
  output logic        dataready,
  output logic        err_frame,
  output logic        err_data
);

  typedef enum logic [1:0] {IDLE, RX, WAIT_IDLE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  bcnt;
  logic [3:0]  dcnt;
  logic [8:0]  sh;
  logic [63:0] shadow;

  logic        stop_edge, frame_ok, is_ctl, pkt_full, store;
  logic        dr_nxt, ef_nxt, ed_nxt;
  logic [2:0]  slot;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!sin) state_nxt = RX;
      RX:        if (bcnt == 4'd9) state_nxt = sin ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (sin) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // sh[8] is the type bit, sh[7:0] the payload, once all 9 bits are in
  always_comb begin
    stop_edge = (state == RX) && (bcnt == 4'd9);
    frame_ok  = stop_edge && sin;
    is_ctl    = sh[8];
    pkt_full  = (dcnt == 4'd8);
    store     = frame_ok && !is_ctl && !pkt_full;
    dr_nxt    = frame_ok && is_ctl && pkt_full;
    ed_nxt    = frame_ok && (is_ctl != pkt_full);
    ef_nxt    = stop_edge && !sin;
    slot      = 3'd7 - dcnt[2:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt      <= '0;
      dcnt      <= '0;
      sh        <= '0;
      shadow    <= '0;
      A         <= '0;
      B         <= '0;
      op        <= '0;
      crc       <= '0;
      dataready <= 1'b0;
      err_frame <= 1'b0;
      err_data  <= 1'b0;
    end else begin
      dataready <= dr_nxt;
      err_frame <= ef_nxt;
      err_data  <= ed_nxt;

      if (state == IDLE && !sin) begin
        bcnt <= '0;
      end else if (state == RX && !stop_edge) begin
        sh   <= {sh[7:0], sin};
        bcnt <= bcnt + 4'd1;
      end

      // Byte 1 lands in shadow[63:56] (B MSB), byte 8 in shadow[7:0] (A LSB)
      if (store) begin
        shadow[{slot, 3'b000} +: 8] <= sh[7:0];
        dcnt <= dcnt + 4'd1;
      end else if (stop_edge) begin
        dcnt <= '0;
      end

      if (dr_nxt) begin
        B   <= shadow[63:32];
        A   <= shadow[31:0];
        op  <= sh[6:4];
        crc <= sh[3:0];
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: directed and random packets checked against a packet-level model.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] A, B;
  logic [2:0]  op;
  logic [3:0]  crc;
  logic        dataready, err_frame, err_data;

  mtm_alu_deserializer dut (
    .clk(clk), .rst(rst), .sin(sin), .A(A), .B(B), .op(op), .crc(crc),
    .dataready(dataready), .err_frame(err_frame), .err_data(err_data)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_dr  = 0;
  logic [2:0]  stray    = '0;

  // packet-level model
  int unsigned m_cnt = 0;
  logic [7:0]  m_bytes [8];
  logic [31:0] m_A = '0, m_B = '0;
  logic [2:0]  m_op = '0;
  logic [3:0]  m_crc = '0;

  localparam logic [2:0] P_NONE = 3'b000, P_DR = 3'b100, P_EF = 3'b010, P_ED = 3'b001;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2:0] pulses();
    return {dataready, err_frame, err_data};
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".A"}, A, m_A);
    check_val({tag, ".B"}, B, m_B);
    check_val({tag, ".op"}, op, m_op);
    check_val({tag, ".crc"}, crc, m_crc);
  endtask

  // Model the effect of one complete frame; returns the expected pulse set
  function automatic logic [2:0] model_frame(input bit ctl, input logic [7:0] pl, input bit stop);
    if (!stop) begin
      m_cnt = 0;
      return P_EF;
    end
    if (!ctl) begin
      if (m_cnt < 8) begin
        m_bytes[m_cnt] = pl;
        m_cnt++;
        return P_NONE;
      end
      m_cnt = 0;
      return P_ED;
    end
    if (m_cnt == 8) begin
      m_B   = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      m_A   = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
      m_op  = pl[6:4];
      m_crc = pl[3:0];
      m_cnt = 0;
      return P_DR;
    end
    m_cnt = 0;
    return P_ED;
  endfunction

  task automatic idle(input int unsigned n, input bit level);
    for (int unsigned i = 0; i < n; i++) begin
      sin = level;
      tick();
      stray |= pulses();
    end
  endtask

  task automatic send_frame(input bit ctl, input logic [7:0] pl, input bit stop,
                            input int unsigned hold, input int unsigned gap);
    logic [10:0] f;
    logic [2:0]  exp;
    int unsigned g;
    f = {1'b0, ctl, pl, stop};
    for (int i = 10; i >= 0; i--) begin
      sin = f[i];
      tick();
      if (i != 0) stray |= pulses();
    end
    exp = model_frame(ctl, pl, stop);
    check_val("pulse", pulses(), exp);
    check_val("stray", stray, 0);
    stray = '0;
    if (exp == P_DR && dataready) last_dr = cyc;
    check_outputs("frame");
    g = (!stop && gap == 0) ? 1 : gap;
    idle(hold, 1'b0);
    idle(g, 1'b1);
  endtask

  task automatic send_packet(input logic [63:0] data, input logic [7:0] ctlb, input int unsigned gap);
    logic [63:0] d;
    d = data;
    for (int i = 0; i < 8; i++) send_frame(1'b0, d[63 - 8*i -: 8], 1'b1, 0, gap);
    send_frame(1'b1, ctlb, 1'b1, 0, gap);
  endtask

  localparam logic [63:0] PKT1 = 64'h11223344_A5A55A5A;

  initial begin
    int unsigned t1;
    logic [10:0] f;

    // reset
    rst = 1'b0;
    tick(); tick();
    check_outputs("reset");
    check_val("reset.pulse", pulses(), 0);
    rst = 1'b1;
    idle(3, 1'b1);

    // valid packet, no gaps, then gaps of 1 and 37
    send_packet(PKT1, 8'h4B, 0);
    check_val("pkt1.B", B, 32'h11223344);
    check_val("pkt1.A", A, 32'hA5A55A5A);
    check_val("pkt1.opcrc", {op, crc}, {3'b100, 4'hB});
    send_packet(PKT1 ^ 64'hFF, 8'h4B, 1);
    send_packet(PKT1, 8'h4B, 37);

    // bad stop on 3rd DATA frame, line held low 5 cycles, then a valid packet
    send_frame(1'b0, 8'h01, 1'b1, 0, 0);
    send_frame(1'b0, 8'h02, 1'b1, 0, 0);
    send_frame(1'b0, 8'h03, 1'b0, 5, 1);
    send_packet(64'h0102030405060708, 8'h25, 0);

    // short packet, then 9 DATA frames, then its CTL
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hC0 + 8'(i), 1'b1, 0, 0);
    send_frame(1'b1, 8'h33, 1'b1, 0, 0);
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'h90 + 8'(i), 1'b1, 0, 0);
    send_frame(1'b1, 8'h33, 1'b1, 0, 2);

    // back-to-back packets, dataready 99 cycles apart
    send_packet(PKT1, 8'h4B, 0);
    t1 = last_dr;
    send_packet('1, 8'h7F, 0);
    check_val("b2b.spacing", last_dr - t1, 99);
    check_val("b2b.AB", {A, B}, '1);
    check_val("b2b.opcrc", {op, crc}, {3'b111, 4'hF});

    // reset during the 6th DATA frame
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'h60 + 8'(i), 1'b1, 0, 0);
    f = {1'b0, 1'b0, 8'hAA, 1'b1};
    for (int i = 10; i >= 6; i--) begin
      sin = f[i];
      tick();
      stray |= pulses();
    end
    sin = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_cnt = 0; m_A = '0; m_B = '0; m_op = '0; m_crc = '0;
    check_outputs("rst_mid");
    check_val("rst_mid.pulse", pulses(), 0);
    idle(2, 1'b1);
    send_frame(1'b0, 8'h77, 1'b1, 0, 0);
    send_frame(1'b0, 8'h88, 1'b1, 0, 0);
    send_frame(1'b1, 8'h4B, 1'b1, 0, 0);
    send_packet(64'hDEADBEEF_CAFEF00D, 8'h9A, 0);

    // random packets: variable length, gaps and occasional framing errors
    for (int p = 0; p < 30; p++) begin
      int unsigned n, bad;
      n   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 8;
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n) : 99;
      for (int unsigned i = 0; i <= n; i++) begin
        send_frame(i == n, 8'($urandom), (i != bad), (i == bad) ? $urandom_range(0, 4) : 0,
                   $urandom_range(0, 3));
      end
    end

    idle(20, 1'b1);
    check_val("final.stray", stray, 0);
    check_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
